// File: rtl/alu_iter.sv
// alu_iter: execute-stage ALU with single-cycle logic/arith ops and iterative
// unsigned multiply / divide (WIDTH cycles each). Results and flags are
// registered and held until the next operation completes.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start, I          request and 4-bit opcode (sampled when busy=0)
//   op1, op2          operands (sampled with an accepted start)
//   res1, res2        primary result; MUL high half / DIVU remainder
//   carry, z          carry/borrow/overflow flag; res1 == 0
//   busy, done        iterative op in progress; one-cycle result-updated pulse
module alu_iter #(
    parameter int unsigned WIDTH = 32,
    localparam int unsigned SHW = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       I,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    output logic [WIDTH-1:0] res1,
    output logic [WIDTH-1:0] res2,
    output logic             carry,
    output logic             z,
    output logic             busy,
    output logic             done
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    logic [0:0]       state_q;
    logic [SHW-1:0]   cnt_q;
    logic             is_mul_q;
    logic [WIDTH-1:0] dvsr_q;   // multiplicand (MUL) or divisor (DIVU)
    logic [WIDTH-1:0] hi_q;     // product high half / partial remainder
    logic [WIDTH-1:0] lo_q;     // multiplier / dividend-then-quotient
    logic [WIDTH-1:0] res1_q, res2_q;
    logic             carry_q, z_q, done_q;

    // Single-cycle datapath.
    logic [WIDTH-1:0] sc_res;
    logic             sc_carry;
    logic [WIDTH:0]   sc_sum;

    always_comb begin
        sc_res   = {WIDTH{1'b0}};
        sc_carry = 1'b0;
        sc_sum   = {1'b0, op1} + {1'b0, op2};
        case (I)
            4'd1: begin
                sc_res   = sc_sum[WIDTH-1:0];
                sc_carry = sc_sum[WIDTH];
            end
            4'd2: begin
                sc_res   = op1 - op2;
                sc_carry = (op1 < op2);
            end
            4'd3:    sc_res = op1 & op2;
            4'd4:    sc_res = op1 | op2;
            4'd5:    sc_res = op1 ^ op2;
            4'd6:    sc_res = op1 << op2[SHW-1:0];
            4'd7:    sc_res = op1 >> op2[SHW-1:0];
            4'd8:    sc_res = (op1 == {WIDTH{1'b0}}) ? op2 : {WIDTH{1'b0}};
            4'd9:    sc_res = (op1 != {WIDTH{1'b0}}) ? op2 : {WIDTH{1'b0}};
            4'd10:   sc_res = {{(WIDTH-1){1'b0}}, (op1 == op2)};
            4'd11:   sc_res = {{(WIDTH-1){1'b0}}, (op1 <= op2)};
            4'd12:   sc_res = {{(WIDTH-1){1'b0}}, (op1 < op2)};
            4'd13:   sc_res = {{(WIDTH-1){1'b0}}, (op1 != op2)};
            default: ; // NOP, and MUL/DIVU which are handled iteratively
        endcase
    end

    // One iteration step of shift-add multiply or restoring divide.
    logic [WIDTH-1:0] addend, mul_hi_n, mul_lo_n;
    logic [WIDTH:0]   add_sum, shifted;
    logic [WIDTH-1:0] diff, div_hi_n, div_lo_n;
    logic             ge;
    logic [WIDTH-1:0] step_hi, step_lo;
    logic             last;

    always_comb begin
        addend   = lo_q[0] ? dvsr_q : {WIDTH{1'b0}};
        add_sum  = {1'b0, hi_q} + {1'b0, addend};
        mul_hi_n = add_sum[WIDTH:1];
        mul_lo_n = {add_sum[0], lo_q[WIDTH-1:1]};

        shifted  = {hi_q, lo_q[WIDTH-1]};
        ge       = (shifted >= {1'b0, dvsr_q});
        // When ge holds the true difference is below the divisor, so the
        // modulo-2^WIDTH subtraction is exact.
        diff     = shifted[WIDTH-1:0] - dvsr_q;
        div_hi_n = ge ? diff : shifted[WIDTH-1:0];
        div_lo_n = {lo_q[WIDTH-2:0], ge};

        step_hi  = is_mul_q ? mul_hi_n : div_hi_n;
        step_lo  = is_mul_q ? mul_lo_n : div_lo_n;
        last     = (cnt_q == SHW'(WIDTH - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            is_mul_q <= 1'b0;
            dvsr_q   <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            res1_q   <= '0;
            res2_q   <= '0;
            carry_q  <= 1'b0;
            z_q      <= 1'b1;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (I[3:1] == 3'b111) begin
                            state_q  <= RUN;
                            cnt_q    <= '0;
                            is_mul_q <= ~I[0];
                            dvsr_q   <= op2;
                            hi_q     <= '0;
                            lo_q     <= op1;
                        end else begin
                            res1_q  <= sc_res;
                            res2_q  <= '0;
                            carry_q <= sc_carry;
                            z_q     <= (sc_res == {WIDTH{1'b0}});
                            done_q  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    hi_q  <= step_hi;
                    lo_q  <= step_lo;
                    cnt_q <= cnt_q + 1'b1;
                    if (last) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                        res1_q  <= step_lo;
                        res2_q  <= step_hi;
                        // MUL: overflow into high half; DIVU: divide by zero.
                        carry_q <= is_mul_q ? (step_hi != {WIDTH{1'b0}})
                                            : (dvsr_q == {WIDTH{1'b0}});
                        z_q     <= (step_lo == {WIDTH{1'b0}});
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign res1  = res1_q;
    assign res2  = res2_q;
    assign carry = carry_q;
    assign z     = z_q;
    assign busy  = (state_q == RUN);
    assign done  = done_q;

endmodule

// File: tb/tb_alu_iter.sv
module tb_alu_iter;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [3:0]  I;
    logic [31:0] op1, op2, res1, res2;
    logic        carry, z, busy, done;

    logic        s8_start;
    logic [3:0]  s8_I;
    logic [7:0]  s8_op1, s8_op2, r8_res1, r8_res2;
    logic        r8_carry, r8_z, r8_busy, r8_done;

    int checks = 0;
    int passed = 0;

    alu_iter #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .I(I), .op1(op1), .op2(op2),
        .res1(res1), .res2(res2), .carry(carry), .z(z), .busy(busy), .done(done)
    );

    alu_iter #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(s8_start), .I(s8_I), .op1(s8_op1), .op2(s8_op2),
        .res1(r8_res1), .res2(r8_res2), .carry(r8_carry), .z(r8_z), .busy(r8_busy),
        .done(r8_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one request across a single rising edge; returns #1 after that edge.
    task automatic issue(input logic [3:0] opc, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1;
        I     = opc;
        op1   = a;
        op2   = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        I     = 4'hx;
        op1   = 32'hx;
        op2   = 32'hx;
    endtask

    // Count edges until done rises (bounded); caller has already seen 'base' edges.
    task automatic wait_done(input int base, output int cycles);
        cycles = base;
        while (!done && cycles < 200) begin
            @(posedge clk);
            #1;
            cycles++;
        end
    endtask

    task automatic test_reset;
        checks++; if (res1 !== 32'h0) $display("FAIL reset_res1: got %h want 0", res1); else passed++;
        checks++; if (res2 !== 32'h0) $display("FAIL reset_res2: got %h want 0", res2); else passed++;
        checks++; if ({carry, z, busy, done} !== 4'b0100)
            $display("FAIL reset_flags: got c%b z%b b%b d%b want c0 z1 b0 d0", carry, z, busy, done);
        else passed++;
        checks++; if ({r8_res1, r8_res2, r8_carry, r8_z, r8_busy, r8_done} !== {16'h0, 4'b0100})
            $display("FAIL reset_w8: got %h %h c%b z%b b%b d%b", r8_res1, r8_res2, r8_carry, r8_z,
                     r8_busy, r8_done);
        else passed++;
    endtask

    task automatic test_add_sub;
        issue(4'd1, 32'hFFFF_FFFF, 32'h1);
        checks++; if (done !== 1'b1) $display("FAIL add_done: got %b want 1", done); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL add_busy: got %b want 0", busy); else passed++;
        checks++; if ({res1, carry, z} !== {32'h0, 2'b11})
            $display("FAIL add_result: got %h c%b z%b want 0 c1 z1", res1, carry, z);
        else passed++;
        checks++; if (res2 !== 32'h0) $display("FAIL add_res2: got %h want 0", res2); else passed++;
        @(posedge clk); #1;
        checks++; if (done !== 1'b0) $display("FAIL add_done_pulse: got %b want 0", done); else passed++;
        checks++; if (res1 !== 32'h0 || carry !== 1'b1)
            $display("FAIL add_hold: got %h c%b want 0 c1", res1, carry);
        else passed++;
        issue(4'd2, 32'd3, 32'd5);
        checks++; if ({res1, carry, z, done} !== {32'hFFFF_FFFE, 3'b101})
            $display("FAIL sub_result: got %h c%b z%b d%b want fffffffe c1 z0 d1", res1, carry, z,
                     done);
        else passed++;
    endtask

    task automatic test_shift_compare;
        issue(4'd6, 32'h1, 32'h3F);
        checks++; if (res1 !== 32'h8000_0000 || carry !== 1'b0)
            $display("FAIL sll_31: got %h c%b want 80000000 c0", res1, carry);
        else passed++;
        issue(4'd12, 32'd5, 32'd7);
        checks++; if ({res1, carry, z} !== {32'h1, 2'b00})
            $display("FAIL slt: got %h c%b z%b want 1 c0 z0", res1, carry, z);
        else passed++;
        issue(4'd10, 32'd4, 32'd4);
        checks++; if (res1 !== 32'h1) $display("FAIL seq: got %h want 1", res1); else passed++;
        issue(4'd11, 32'd7, 32'd5);
        checks++; if (res1 !== 32'h0 || z !== 1'b1)
            $display("FAIL sle_false: got %h z%b want 0 z1", res1, z);
        else passed++;
        issue(4'd11, 32'd5, 32'd5);
        checks++; if (res1 !== 32'h1) $display("FAIL sle_equal: got %h want 1", res1); else passed++;
        issue(4'd9, 32'd2, 32'hABCD);
        checks++; if (res1 !== 32'hABCD) $display("FAIL op9_nz: got %h want abcd", res1); else passed++;
        issue(4'd0, 32'h1234, 32'h5678);
        checks++; if ({res1, carry, z, done} !== {32'h0, 3'b011})
            $display("FAIL nop: got %h c%b z%b d%b want 0 c0 z1 d1", res1, carry, z, done);
        else passed++;
    endtask

    task automatic test_back_to_back;
        logic [3:0]  vi [8];
        logic [31:0] va [8];
        logic [31:0] vb [8];
        logic [31:0] vr [8];
        vi = '{4'd1, 4'd3, 4'd4, 4'd5, 4'd7, 4'd8, 4'd9, 4'd13};
        va = '{32'd10, 32'hF0F0, 32'hF0F0, 32'hFF00, 32'h8000_0000, 32'h0, 32'h0, 32'd3};
        vb = '{32'd20, 32'hFF00, 32'h0F0F, 32'h0FF0, 32'h24, 32'h1234, 32'h55, 32'd3};
        vr = '{32'd30, 32'hF000, 32'hFFFF, 32'hF0F0, 32'h0800_0000, 32'h1234, 32'h0, 32'h0};
        for (int i = 0; i < 8; i++) begin
            start = 1'b1;
            I     = vi[i];
            op1   = va[i];
            op2   = vb[i];
            @(posedge clk);
            #1;
            checks++; if ({done, busy, carry} !== 3'b100 || res1 !== vr[i])
                $display("FAIL b2b_%0d: got %h d%b b%b c%b want %h d1 b0 c0", i, res1, done, busy,
                         carry, vr[i]);
            else passed++;
        end
        start = 1'b0;
        @(posedge clk); #1;
        checks++; if (done !== 1'b0) $display("FAIL b2b_end_done: got %b want 0", done); else passed++;
    endtask

    task automatic test_mul;
        int cyc;
        issue(4'd14, 32'h0001_0000, 32'h0001_0000);
        checks++; if (busy !== 1'b1 || done !== 1'b0)
            $display("FAIL mul_busy: got b%b d%b want b1 d0", busy, done);
        else passed++;
        wait_done(0, cyc);
        checks++; if (cyc !== 32) $display("FAIL mul_latency: got %0d want 32", cyc); else passed++;
        checks++; if ({res1, res2, carry, z, busy} !== {32'h0, 32'h1, 3'b110})
            $display("FAIL mul_big: got %h %h c%b z%b b%b want 0 1 c1 z1 b0", res1, res2, carry, z,
                     busy);
        else passed++;
        issue(4'd14, 32'd6, 32'd7);
        wait_done(0, cyc);
        checks++; if (cyc !== 32 || {res1, res2, carry, z} !== {32'd42, 32'h0, 2'b00})
            $display("FAIL mul_6x7: got %h %h c%b z%b lat %0d want 2a 0 c0 z0 lat 32", res1, res2,
                     carry, z, cyc);
        else passed++;
    endtask

    task automatic test_divu;
        int cyc;
        issue(4'd15, 32'd100, 32'd7);
        wait_done(0, cyc);
        checks++; if (cyc !== 32 || {res1, res2, carry} !== {32'd14, 32'd2, 1'b0})
            $display("FAIL divu_100_7: got %h %h c%b lat %0d want e 2 c0 lat 32", res1, res2, carry,
                     cyc);
        else passed++;
        issue(4'd15, 32'd9, 32'd0);
        wait_done(0, cyc);
        checks++; if (cyc !== 32 || {res1, res2, carry, z} !== {32'hFFFF_FFFF, 32'd9, 2'b10})
            $display("FAIL divu_by0: got %h %h c%b z%b lat %0d want ffffffff 9 c1 z0 lat 32", res1,
                     res2, carry, z, cyc);
        else passed++;
    endtask

    task automatic test_ignore_busy;
        int cyc;
        issue(4'd15, 32'd100, 32'd7);
        repeat (3) begin @(posedge clk); #1; end
        start = 1'b1; I = 4'd1; op1 = 32'd1; op2 = 32'd1;
        @(posedge clk); #1;
        start = 1'b0;
        checks++; if (done !== 1'b0 || busy !== 1'b1)
            $display("FAIL ignore_accept: got d%b b%b want d0 b1", done, busy);
        else passed++;
        wait_done(4, cyc);
        checks++; if (cyc !== 32 || {res1, res2, carry} !== {32'd14, 32'd2, 1'b0})
            $display("FAIL ignore_result: got %h %h c%b lat %0d want e 2 c0 lat 32", res1, res2,
                     carry, cyc);
        else passed++;
    endtask

    task automatic test_reset_mid_run;
        int cyc;
        issue(4'd15, 32'd100, 32'd7);
        repeat (9) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        checks++; if ({res1, res2, carry, z, busy, done} !== {64'h0, 4'b0100})
            $display("FAIL midrst_outputs: got %h %h c%b z%b b%b d%b want 0 0 c0 z1 b0 d0", res1,
                     res2, carry, z, busy, done);
        else passed++;
        repeat (3) begin @(posedge clk); #1; end
        rst_n = 1'b1;
        repeat (30) begin @(posedge clk); #1; end
        checks++; if (done !== 1'b0 || busy !== 1'b0 || res1 !== 32'h0)
            $display("FAIL midrst_no_done: got d%b b%b %h want d0 b0 0", done, busy, res1);
        else passed++;
        issue(4'd14, 32'd1000, 32'd1000);
        wait_done(0, cyc);
        checks++; if (cyc !== 32 || {res1, res2, carry} !== {32'h000F_4240, 32'h0, 1'b0})
            $display("FAIL midrst_mul: got %h %h c%b lat %0d want f4240 0 c0 lat 32", res1, res2,
                     carry, cyc);
        else passed++;
    endtask

    task automatic test_width8;
        int cyc;
        s8_start = 1'b1; s8_I = 4'd14; s8_op1 = 8'hFF; s8_op2 = 8'hFF;
        @(posedge clk); #1;
        s8_start = 1'b0;
        cyc = 0;
        while (!r8_done && cyc < 50) begin @(posedge clk); #1; cyc++; end
        checks++; if (cyc !== 8 || {r8_res1, r8_res2, r8_carry} !== {8'h01, 8'hFE, 1'b1})
            $display("FAIL w8_mul: got %h %h c%b lat %0d want 01 fe c1 lat 8", r8_res1, r8_res2,
                     r8_carry, cyc);
        else passed++;
        s8_start = 1'b1; s8_I = 4'd7; s8_op1 = 8'h80; s8_op2 = 8'h0B;
        @(posedge clk); #1;
        s8_start = 1'b0;
        checks++; if (r8_res1 !== 8'h10 || r8_res2 !== 8'h0 || r8_done !== 1'b1)
            $display("FAIL w8_srl: got %h %h d%b want 10 00 d1", r8_res1, r8_res2, r8_done);
        else passed++;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; I = 4'd0; op1 = '0; op2 = '0;
        s8_start = 1'b0; s8_I = 4'd0; s8_op1 = '0; s8_op2 = '0;
        repeat (3) @(posedge clk);
        #1;
        test_reset;
        rst_n = 1'b1;
        @(posedge clk); #1;
        test_add_sub;
        test_shift_compare;
        test_back_to_back;
        test_mul;
        test_divu;
        test_ignore_busy;
        test_reset_mid_run;
        test_width8;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
